lsu_ctrl: RTL and testbench

- Load/store unit sitting directly downstream of the execute-stage memory request generator.
- Consumes per-instruction mem_addr / mem_w / mem_r_en / mem_w_en plus access size and drives a word-wide data-memory bus with a valid/ready handshake.
- Generates byte strobes and lane-shifted write data, checks alignment and address range, and returns sign- or zero-extended load data with an error flag as a one-cycle response to writeback.

---
 rtl/lsu_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one execute-stage memory request into a single word-wide
// bus transaction and returns a one-cycle, extended, error-flagged response.
module lsu_ctrl #(
    parameter int unsigned              ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0]     BASE_ADDR = 32'h80000000,
    parameter logic [ISA_WIDTH-1:0]     MEM_SIZE  = 32'h08000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ISA_WIDTH-1:0] req_addr,
    input  logic [ISA_WIDTH-1:0] req_wdata,
    input  logic                 req_r_en,
    input  logic                 req_w_en,
    input  logic [2:0]           req_size,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [ISA_WIDTH-1:0] bus_addr,
    output logic                 bus_we,
    output logic [3:0]           bus_wstrb,
    output logic [ISA_WIDTH-1:0] bus_wdata,
    input  logic                 bus_rvalid,
    input  logic [ISA_WIDTH-1:0] bus_rdata,
    input  logic                 bus_err,
    output logic                 resp_valid,
    output logic [ISA_WIDTH-1:0] resp_rdata,
    output logic                 resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                 state_q;
    logic                   req_ready_q, bus_valid_q, bus_we_q;
    logic [ISA_WIDTH-1:0]   bus_addr_q, bus_wdata_q;
    logic [3:0]             bus_wstrb_q;
    logic                   resp_valid_q, resp_err_q;
    logic [ISA_WIDTH-1:0]   resp_rdata_q;
    logic [1:0]             lane_q;
    logic [2:0]             size_q;
    logic                   load_q;

    logic                   accept, noop, bad, misal, in_range;
    logic [ISA_WIDTH-1:0]   offs, wdata_d, ld_data;
    logic [3:0]             strb_d;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;

    always_comb begin
        accept   = req_valid & req_ready_q;
        noop     = !req_r_en && !req_w_en;
        // Subtraction wraps below BASE_ADDR, so a single unsigned compare covers both ends.
        offs     = req_addr - BASE_ADDR;
        in_range = offs < MEM_SIZE;
        misal    = (req_size[1:0] == 2'd1 && req_addr[0]) ||
                   (req_size[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
        bad      = !noop && ((req_r_en && req_w_en) || req_size[1:0] == 2'd3 || misal || !in_range);
        strb_d   = 4'b0000;
        wdata_d  = req_wdata;
        case (req_size[1:0])
            2'd0: begin
                strb_d  = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_d  = 4'b0011 << req_addr[1:0];
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: strb_d = 4'b1111;
        endcase
        if (!req_w_en) strb_d = 4'b0000;
    end

    always_comb begin
        byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q[1:0])
            2'd0:    ld_data = size_q[2] ? {{(ISA_WIDTH-8){1'b0}}, byte_sel}
                                         : {{(ISA_WIDTH-8){byte_sel[7]}}, byte_sel};
            2'd1:    ld_data = size_q[2] ? {{(ISA_WIDTH-16){1'b0}}, half_sel}
                                         : {{(ISA_WIDTH-16){half_sel[15]}}, half_sel};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= BASE_ADDR;
            bus_we_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0000;
            bus_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            lane_q       <= 2'b00;
            size_q       <= 3'b000;
            load_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    req_ready_q <= 1'b0;
                    if (noop || bad) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= bad;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q     <= REQ;
                        bus_valid_q <= 1'b1;
                        bus_addr_q  <= {req_addr[ISA_WIDTH-1:2], 2'b00};
                        bus_we_q    <= req_w_en;
                        bus_wstrb_q <= strb_d;
                        bus_wdata_q <= req_w_en ? wdata_d : '0;
                        lane_q      <= req_addr[1:0];
                        size_q      <= req_size;
                        load_q      <= req_r_en;
                    end
                end
                REQ: if (bus_ready) begin
                    state_q     <= WAIT;
                    bus_valid_q <= 1'b0;
                    bus_addr_q  <= BASE_ADDR;
                    bus_we_q    <= 1'b0;
                    bus_wstrb_q <= 4'b0000;
                    bus_wdata_q <= '0;
                end
                WAIT: if (bus_rvalid) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= bus_err;
                    resp_rdata_q <= (bus_err || !load_q) ? '0 : ld_data;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_valid  = bus_valid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_we     = bus_we_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_wdata  = bus_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: each scenario task drives one request through a
// bench-side bus responder and checks the response against hand-computed values.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_r_en = 1'b0, req_w_en = 1'b0;
    logic [2:0]  req_size = '0;
    logic        bus_valid, bus_ready = 1'b0;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int tests = 0;
    int fails = 0;

    // Results of the last run_req
    logic        r_done, r_err, r_stable, r_we, r_post;
    int          r_lat, r_bv;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_strb;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_r_en(req_r_en), .req_w_en(req_w_en),
        .req_size(req_size),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request (from IDLE) and plays the bus: holds bus_ready low for
    // 'stall' bus_valid cycles, then returns rvalid in the first WAIT cycle.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic r, input logic w, input logic [2:0] size,
                           input logic [31:0] rd, input logic berr, input int stall);
        int  st;
        logic hs;
        st = stall; hs = 1'b0;
        r_done = 1'b0; r_lat = 0; r_bv = 0; r_stable = 1'b1;
        r_rdata = 'x; r_err = 1'bx; r_addr = 'x; r_we = 1'bx; r_strb = 'x; r_wdata = 'x;
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata;
        req_r_en = r; req_w_en = w; req_size = size;
        for (int i = 0; i < 30; i++) begin
            tick();
            r_lat++;
            req_valid = 1'b0; bus_rvalid = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
            if (resp_valid) begin
                r_done = 1'b1; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
            if (bus_valid) begin
                r_bv++;
                if (r_bv == 1) begin
                    r_addr = bus_addr; r_we = bus_we; r_strb = bus_wstrb; r_wdata = bus_wdata;
                end else if (bus_addr !== r_addr || bus_we !== r_we ||
                             bus_wstrb !== r_strb || bus_wdata !== r_wdata) begin
                    r_stable = 1'b0;
                end
                if (st > 0) st--;
                else bus_ready = 1'b1;
                hs = bus_ready;
            end else if (hs) begin
                bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr; hs = 1'b0;
            end
        end
        tick();
        r_post = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid got %b want 0", bus_valid); end
        tests++; if (bus_addr !== 32'h80000000) begin fails++; $display("FAIL reset_bus_addr got %h want 80000000", bus_addr); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        tests++; if (bus_wstrb !== 4'b0000 || resp_err !== 1'b0) begin fails++; $display("FAIL reset_misc got strb=%b err=%b want 0000/0", bus_wstrb, resp_err); end
    endtask

    task automatic test_load_ext();
        run_req(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF1234, 1'b0, 0);
        tests++; if (r_done !== 1'b1 || r_lat != 3) begin fails++; $display("FAIL sbyte_latency got done=%b lat=%0d want 1/3", r_done, r_lat); end
        tests++; if (r_addr !== 32'h80000000 || r_strb !== 4'b0000 || r_we !== 1'b0) begin fails++; $display("FAIL sbyte_bus got addr=%h strb=%b we=%b want 80000000/0000/0", r_addr, r_strb, r_we); end
        tests++; if (r_rdata !== 32'hFFFFFF80 || r_err !== 1'b0) begin fails++; $display("FAIL sbyte_data got %h err=%b want ffffff80/0", r_rdata, r_err); end
        tests++; if (r_post !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL sbyte_one_cycle got post=%b ready=%b want 0/1", r_post, req_ready); end
        run_req(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF1234, 1'b0, 0);
        tests++; if (r_rdata !== 32'h00000080 || r_err !== 1'b0) begin fails++; $display("FAIL ubyte_data got %h err=%b want 00000080/0", r_rdata, r_err); end
        run_req(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b001, 32'h80FF1234, 1'b0, 0);
        tests++; if (r_rdata !== 32'hFFFF80FF) begin fails++; $display("FAIL shalf_data got %h want ffff80ff", r_rdata); end
        run_req(32'h80000001, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF1234, 1'b0, 0);
        tests++; if (r_rdata !== 32'h00000012) begin fails++; $display("FAIL ubyte_lane1 got %h want 00000012", r_rdata); end
    endtask

    task automatic test_store();
        run_req(32'h80000102, 32'hDEADBEEF, 1'b0, 1'b1, 3'b001, 32'h0, 1'b0, 4);
        tests++; if (r_addr !== 32'h80000100 || r_we !== 1'b1) begin fails++; $display("FAIL hstore_addr got addr=%h we=%b want 80000100/1", r_addr, r_we); end
        tests++; if (r_strb !== 4'b1100 || r_wdata !== 32'hBEEFBEEF) begin fails++; $display("FAIL hstore_payload got strb=%b wdata=%h want 1100/beefbeef", r_strb, r_wdata); end
        tests++; if (r_stable !== 1'b1 || r_bv != 5) begin fails++; $display("FAIL hstore_stall got stable=%b valid_cycles=%0d want 1/5", r_stable, r_bv); end
        tests++; if (r_done !== 1'b1 || r_lat != 7 || r_rdata !== 32'h0 || r_err !== 1'b0) begin fails++; $display("FAIL hstore_resp got done=%b lat=%0d rdata=%h err=%b want 1/7/0/0", r_done, r_lat, r_rdata, r_err); end
        run_req(32'h80000001, 32'h123456A5, 1'b0, 1'b1, 3'b000, 32'hFFFFFFFF, 1'b0, 0);
        tests++; if (r_strb !== 4'b0010 || r_wdata !== 32'hA5A5A5A5 || r_rdata !== 32'h0) begin fails++; $display("FAIL bstore got strb=%b wdata=%h rdata=%h want 0010/a5a5a5a5/0", r_strb, r_wdata, r_rdata); end
        run_req(32'h80000004, 32'hCAFEF00D, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 0);
        tests++; if (r_strb !== 4'b1111 || r_wdata !== 32'hCAFEF00D || r_addr !== 32'h80000004) begin fails++; $display("FAIL wstore got strb=%b wdata=%h addr=%h want 1111/cafef00d/80000004", r_strb, r_wdata, r_addr); end
    endtask

    task automatic test_errors();
        run_req(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0, 0);
        tests++; if (r_lat != 1 || r_err !== 1'b1 || r_bv != 0 || r_rdata !== 32'h0) begin fails++; $display("FAIL misal_word got lat=%0d err=%b bus=%0d rdata=%h want 1/1/0/0", r_lat, r_err, r_bv, r_rdata); end
        run_req(32'h80000001, 32'h0, 1'b1, 1'b0, 3'b001, 32'h0, 1'b0, 0);
        tests++; if (r_lat != 1 || r_err !== 1'b1 || r_bv != 0) begin fails++; $display("FAIL misal_half got lat=%0d err=%b bus=%0d want 1/1/0", r_lat, r_err, r_bv); end
        run_req(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 1'b0, 0);
        tests++; if (r_err !== 1'b1 || r_bv != 0) begin fails++; $display("FAIL bad_size got err=%b bus=%0d want 1/0", r_err, r_bv); end
        run_req(32'h80000000, 32'h0, 1'b1, 1'b1, 3'b010, 32'h0, 1'b0, 0);
        tests++; if (r_err !== 1'b1 || r_bv != 0) begin fails++; $display("FAIL both_en got err=%b bus=%0d want 1/0", r_err, r_bv); end
        run_req(32'h80000003, 32'h0, 1'b0, 1'b0, 3'b011, 32'h0, 1'b0, 0);
        tests++; if (r_lat != 1 || r_err !== 1'b0 || r_bv != 0 || r_rdata !== 32'h0) begin fails++; $display("FAIL noop got lat=%0d err=%b bus=%0d rdata=%h want 1/0/0/0", r_lat, r_err, r_bv, r_rdata); end
    endtask

    task automatic test_range();
        run_req(32'h7FFFFFFC, 32'h11111111, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0, 0);
        tests++; if (r_lat != 1 || r_err !== 1'b1 || r_bv != 0) begin fails++; $display("FAIL range_low got lat=%0d err=%b bus=%0d want 1/1/0", r_lat, r_err, r_bv); end
        run_req(32'h88000000, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0, 0);
        tests++; if (r_lat != 1 || r_err !== 1'b1 || r_bv != 0) begin fails++; $display("FAIL range_high got lat=%0d err=%b bus=%0d want 1/1/0", r_lat, r_err, r_bv); end
        run_req(32'h87FFFFFC, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0000CAFE, 1'b0, 0);
        tests++; if (r_lat != 3 || r_err !== 1'b0 || r_rdata !== 32'h0000CAFE || r_addr !== 32'h87FFFFFC) begin fails++; $display("FAIL range_top got lat=%0d err=%b rdata=%h addr=%h want 3/0/0000cafe/87fffffc", r_lat, r_err, r_rdata, r_addr); end
    endtask

    task automatic test_bus_err_and_reset();
        logic seen;
        run_req(32'h80000010, 32'h0, 1'b1, 1'b0, 3'b010, 32'hDEADBEEF, 1'b1, 0);
        tests++; if (r_done !== 1'b1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin fails++; $display("FAIL bus_err got done=%b err=%b rdata=%h want 1/1/0", r_done, r_err, r_rdata); end
        // Second load abandoned by reset while waiting for the bus response
        req_valid = 1'b1; req_addr = 32'h80000020; req_r_en = 1'b1; req_w_en = 1'b0; req_size = 3'b010;
        bus_ready = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); bus_ready = 1'b0;
        tests++; if (bus_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL midflight_wait got valid=%b ready=%b want 0/0", bus_valid, req_ready); end
        rst = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bus_addr !== 32'h80000000) begin fails++; $display("FAIL midflight_reset got ready=%b rv=%b addr=%h want 1/0/80000000", req_ready, resp_valid, bus_addr); end
        tick(); rst = 1'b1;
        seen = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_rvalid = 1'b0;
            if (resp_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL orphan_resp got resp=%b ready=%b want 0/1", seen, req_ready); end
        run_req(32'h80000040, 32'h0, 1'b1, 1'b0, 3'b010, 32'h12345678, 1'b0, 0);
        tests++; if (r_done !== 1'b1 || r_lat != 3 || r_rdata !== 32'h12345678 || r_err !== 1'b0) begin fails++; $display("FAIL post_reset_load got done=%b lat=%0d rdata=%h err=%b want 1/3/12345678/0", r_done, r_lat, r_rdata, r_err); end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_ext();
        test_store();
        test_errors();
        test_range();
        test_bus_err_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
